ben8_datapath: RTL and testbench

- Downstream consumer of the microcode decoder: holds the SAP-style 8-bit machine state and executes one control word per clock.
- Contents: shared 8-bit bus; A, B, IR, MAR, PC and OUT registers; 16x8 RAM; add/sub ALU.
- The decoder updates control lines on negedge clk. This block samples them and updates state on posedge clk.
- IR is fed back to the decoder as insn.

---
 rtl/ben8_pkg.sv | 49 ++++
 rtl/ben8_alu.sv | 27 ++
 rtl/ben8_datapath.sv | 122 ++++++++++++
 tb/tb_ben8_datapath.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ben8_pkg.sv
// Shared types for the SAP-style 8-bit machine: widths, opcodes and control word.
package ben8_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [3:0] {
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        DRV_NONE = 3'd0,
        DRV_RAM  = 3'd1,
        DRV_IR   = 3'd2,
        DRV_A    = 3'd3,
        DRV_ALU  = 3'd4,
        DRV_PC   = 3'd5
    } bus_drv_t;

    typedef struct packed {
        logic     hlt;
        logic     mi;
        logic     ri;
        logic     ii;
        logic     ai;
        logic     bi;
        logic     oi;
        logic     sub;
        logic     ce;
        logic     j;
        bus_drv_t drv;
    } ctrl_t;

    // Multiple enables are a decoder bug; fixed priority keeps the bus deterministic.
    function automatic bus_drv_t drv_sel(input logic ro, input logic io, input logic ao,
                                         input logic sumo, input logic co);
        if (ro)   return DRV_RAM;
        if (io)   return DRV_IR;
        if (ao)   return DRV_A;
        if (sumo) return DRV_ALU;
        if (co)   return DRV_PC;
        return DRV_NONE;
    endfunction

endpackage

// File: rtl/ben8_alu.sv
// Combinational add/subtract; carry and zero exist only with BEN8_FLAGS_EN.
module ben8_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
`ifdef BEN8_FLAGS_EN
    output logic         carry,
    output logic         zero,
`endif
    output logic [W-1:0] sum
);

`ifdef BEN8_FLAGS_EN
    logic [W:0] full;

    // Two's-complement subtract: carry set means no borrow.
    assign full  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    assign sum   = full[W-1:0];
    assign carry = full[W];
    assign zero  = (full[W-1:0] == '0);
`else
    assign sum = a + (sub ? (~b + W'(1)) : b);
`endif

endmodule

// File: rtl/ben8_datapath.sv
// SAP-style datapath: one control word per posedge, combinational bus, no backpressure.
// Optional BEN8_FLAGS_EN adds fi input and cf/zf flag outputs.
module ben8_datapath #(
    parameter int DATA_W = ben8_pkg::DATA_W,
    parameter int ADDR_W = ben8_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              mi,
    input  logic              ri,
    input  logic              ii,
    input  logic              ai,
    input  logic              bi,
    input  logic              oi,
    input  logic              ro,
    input  logic              io,
    input  logic              ao,
    input  logic              sumo,
    input  logic              co,
    input  logic              sub,
    input  logic              ce,
    input  logic              j,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
`ifdef BEN8_FLAGS_EN
    input  logic              fi,
    output logic              cf,
    output logic              zf,
`endif
    output logic [DATA_W-1:0] insn,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] out_val,
    output logic              out_stb
);
    import ben8_pkg::*;

    logic [DATA_W-1:0] a_q, b_q, ir_q, out_q;
    logic [ADDR_W-1:0] mar_q, pc_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] alu_sum;
    logic              out_stb_q;
    logic              run_wr;
    logic              prog_wr;

    assign run_wr  = !hlt && !prog_mode;
    assign prog_wr = !hlt && prog_mode && prog_we;

`ifdef BEN8_FLAGS_EN
    logic alu_carry, alu_zero;

    ben8_alu #(.W(DATA_W)) u_alu (
        .a(a_q), .b(b_q), .sub(sub), .carry(alu_carry), .zero(alu_zero), .sum(alu_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cf <= 1'b0;
            zf <= 1'b0;
        end else if (fi && !hlt) begin
            cf <= alu_carry;
            zf <= alu_zero;
        end
    end
`else
    ben8_alu #(.W(DATA_W)) u_alu (
        .a(a_q), .b(b_q), .sub(sub), .sum(alu_sum)
    );
`endif

    always_comb begin
        bus = '0;
        case (drv_sel(ro, io, ao, sumo, co))
            DRV_RAM: bus = mem[mar_q];
            DRV_IR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
            DRV_A:   bus = a_q;
            DRV_ALU: bus = alu_sum;
            DRV_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            ir_q      <= '0;
            out_q     <= '0;
            mar_q     <= '0;
            pc_q      <= '0;
            out_stb_q <= 1'b0;
        end else begin
            out_stb_q <= run_wr && oi;
            if (run_wr) begin
                if (mi) mar_q <= bus[ADDR_W-1:0];
                if (ii) ir_q  <= bus;
                if (ai) a_q   <= bus;
                if (bi) b_q   <= bus;
                if (oi) out_q <= bus;
                if (j)       pc_q <= bus[ADDR_W-1:0];
                else if (ce) pc_q <= pc_q + ADDR_W'(1);
            end
        end
    end

    // RAM has no reset; gating on rst drops a write that coincides with reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (prog_wr)
                mem[prog_addr] <= prog_data;
            else if (run_wr && ri)
                mem[mar_q] <= bus;
        end
    end

    assign insn    = ir_q;
    assign out_val = out_q;
    assign out_stb = out_stb_q && !hlt;

endmodule

// File: tb/tb_ben8_datapath.sv
// Directed bench for ben8_datapath; internal registers observed through the bus.
module tb_ben8_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       hlt, mi, ri, ii, ai, bi, oi, ro, io, ao, sumo, co, sub, ce, j;
    logic       prog_mode, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] insn, bus, out_val;
    logic       out_stb;
`ifdef BEN8_FLAGS_EN
    logic       fi, cf, zf;
`endif

    int checks = 0;
    int errors = 0;

    ben8_datapath dut (
        .clk(clk), .rst(rst), .hlt(hlt),
        .mi(mi), .ri(ri), .ii(ii), .ai(ai), .bi(bi), .oi(oi),
        .ro(ro), .io(io), .ao(ao), .sumo(sumo), .co(co),
        .sub(sub), .ce(ce), .j(j),
        .prog_mode(prog_mode), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef BEN8_FLAGS_EN
        .fi(fi), .cf(cf), .zf(zf),
`endif
        .insn(insn), .bus(bus), .out_val(out_val), .out_stb(out_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic clr();
        hlt = 0; mi = 0; ri = 0; ii = 0; ai = 0; bi = 0; oi = 0;
        ro = 0; io = 0; ao = 0; sumo = 0; co = 0; sub = 0; ce = 0; j = 0;
        prog_mode = 0; prog_we = 0; prog_addr = 4'h0; prog_data = 8'h00;
`ifdef BEN8_FLAGS_EN
        fi = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program RAM[0] (MAR is kept at 0) and leave ro driving that value.
    task automatic put(input logic [7:0] v);
        clr(); prog_mode = 1; prog_we = 1; prog_addr = 4'h0; prog_data = v;
        tick();
        clr(); ro = 1;
    endtask

    task automatic peek_a(input string tag, input logic [7:0] exp);
        clr(); ao = 1; #1; check(tag, bus, exp);
    endtask

    task automatic peek_pc(input string tag, input logic [7:0] exp);
        clr(); co = 1; #1; check(tag, bus, exp);
    endtask

    initial begin
        clr();
        rst = 0;
        repeat (2) tick();
        rst = 1;
        tick();

        // Test 1: async reset from a loaded state with PC=7
        put(8'h07); ii = 1; ai = 1; bi = 1; oi = 1; j = 1; tick();
        clr(); #1;
        check("pre_rst_insn", insn, 8'h07);
        check("pre_rst_stb", {7'd0, out_stb}, 8'h01);
        peek_pc("pre_rst_pc", 8'h07);
        #1 rst = 0; #1;
        check("rst_insn", insn, 8'h00);
        check("rst_out", out_val, 8'h00);
        check("rst_stb", {7'd0, out_stb}, 8'h00);
        clr(); #1;
        check("rst_bus_idle", bus, 8'h00);
        peek_pc("rst_pc", 8'h00);
        peek_a("rst_a", 8'h00);
        clr(); sumo = 1; #1; check("rst_b_via_sum", bus, 8'h00);
        rst = 1;
        tick();

        // Test 2: programming mode blocks control writes
        clr(); prog_mode = 1; prog_we = 1; prog_addr = 4'h0; prog_data = 8'h1E; ce = 1; tick();
        clr(); prog_mode = 1; prog_we = 1; prog_addr = 4'hE; prog_data = 8'h2A; ce = 1; tick();
        peek_pc("prog_pc_held", 8'h00);
        clr(); mi = 1; co = 1; tick();
        clr(); ro = 1; ii = 1; tick();
        check("ir_load", insn, 8'h1E);
        peek_pc("pc_after_fetch", 8'h00);
        clr(); io = 1; #1; check("io_low_nibble", bus, 8'h0E);
        mi = 1; tick();
        clr(); ro = 1; #1; check("ram14", bus, 8'h2A);
        clr(); mi = 1; co = 1; tick();
        // ri with mi: write uses pre-edge MAR (0), MAR moves to 14
        clr(); io = 1; mi = 1; ri = 1; tick();
        clr(); ro = 1; #1; check("ri_mi_ram14_kept", bus, 8'h2A);
        clr(); mi = 1; co = 1; tick();
        clr(); ro = 1; #1; check("ri_mi_ram0", bus, 8'h0E);

        // Test 3: ALU add / subtract with wrap
        put(8'h05); ai = 1; tick();
        put(8'h07); bi = 1; tick();
        clr(); sumo = 1; #1; check("sum_bus", bus, 8'h0C);
        ai = 1; tick();
        peek_a("add_a", 8'h0C);
        put(8'h05); ai = 1; tick();
        clr(); sumo = 1; sub = 1; #1; check("sub_bus", bus, 8'hFE);
        ai = 1; tick();
        peek_a("sub_a", 8'hFE);

        // Bus priority
        clr(); ro = 1; io = 1; ao = 1; sumo = 1; co = 1; #1; check("prio_ro", bus, 8'h05);
        ro = 0; #1; check("prio_io", bus, 8'h0E);
        io = 0; #1; check("prio_ao", bus, 8'hFE);

        // Test 4: PC wrap and jump priority over ce
        put(8'h0F); j = 1; tick();
        peek_pc("pc_f", 8'h0F);
        clr(); ce = 1; tick();
        peek_pc("pc_wrap", 8'h00);
        put(8'h03); j = 1; ce = 1; tick();
        peek_pc("pc_jump", 8'h03);

        // Test 5: OUT strobe and halt
        put(8'h42); ai = 1; tick();
        clr(); ao = 1; oi = 1; tick();
        check("out_val", out_val, 8'h42);
        check("out_stb_hi", {7'd0, out_stb}, 8'h01);
        clr(); tick();
        check("out_stb_lo", {7'd0, out_stb}, 8'h00);
        put(8'h99); hlt = 1; ai = 1; oi = 1; ce = 1; #1;
        check("hlt_bus_live", bus, 8'h99);
        tick();
        check("hlt_stb", {7'd0, out_stb}, 8'h00);
        check("hlt_out", out_val, 8'h42);
        peek_a("hlt_a", 8'h42);
        peek_pc("hlt_pc", 8'h03);

        // prog_we outside programming mode is ignored
        clr(); prog_we = 1; prog_addr = 4'h0; prog_data = 8'h55; tick();
        clr(); ro = 1; #1; check("prog_we_ignored", bus, 8'h99);

`ifdef BEN8_FLAGS_EN
        // Test 6: flags
        put(8'h80); ai = 1; bi = 1; tick();
        clr(); sumo = 1; fi = 1; tick();
        check("cf_add", {7'd0, cf}, 8'h01);
        check("zf_add", {7'd0, zf}, 8'h01);
        put(8'h05); ai = 1; tick();
        clr(); sumo = 1; sub = 1; fi = 1; hlt = 1; tick();
        check("cf_hlt_held", {7'd0, cf}, 8'h01);
        clr(); sumo = 1; sub = 1; fi = 1; tick();
        check("cf_borrow", {7'd0, cf}, 8'h00);
        check("zf_nonzero", {7'd0, zf}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
